// File: rtl/router_rx_pkg.sv
// router_rx_pkg - shared types for the router port receive path (rev 1.0)
`default_nettype none

package router_rx_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    FLUSH = 2'd2
  } rx_state_e;

  typedef struct packed {
    logic              last;
    logic [BYTE_W-1:0] data;
  } rx_entry_t;

endpackage

`default_nettype wire

// File: rtl/router_rx_fifo.sv
// router_rx_fifo - synchronous first-word-fall-through FIFO (rev 1.0)
`default_nettype none

module router_rx_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic             w_pop, w_push;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign w_pop   = pop_i && !empty_o;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign w_push  = push_i && (!full_o || w_pop);
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

`default_nettype wire

// File: rtl/router_port_rx.sv
// router_port_rx - router port serial-to-byte deserializer with FWFT output (rev 1.0)
`default_nettype none

module router_port_rx
  import router_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             dout,
  input  logic             frameo_n,
  input  logic             valido_n,
  output logic [7:0]       m_data,
  output logic             m_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] pkt_count,
  output logic             err_partial,
  output logic             err_overflow,
  input  logic             clr_err
);

  localparam int BC_W = $clog2(BYTE_W);
  localparam int EW   = $bits(rx_entry_t);

  rx_state_e         state_q, state_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0] shreg_q, shreg_d;
  logic [BYTE_W-1:0] hold_q, hold_d;
  logic              hold_vld_q, hold_vld_d;
  logic              push_q, push_d;
  rx_entry_t         entry_q, entry_d;
  logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic              err_part_q, err_part_d;
  logic              err_ovf_q, err_ovf_d;
  logic              set_part;

  logic              fifo_full, fifo_empty;
  logic [EW-1:0]     fifo_dout;
  rx_entry_t         head;
  logic              w_pop, w_drop;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    pkt_cnt_d  = pkt_cnt_q;
    push_d     = 1'b0;
    entry_d    = '0;
    set_part   = 1'b0;

    case (state_q)
      RECV: begin
        if (!valido_n) begin
          shreg_d[bit_cnt_q] = dout;
          if (bit_cnt_q == BC_W'(BYTE_W - 1)) begin
            if (hold_vld_q) begin
              push_d  = 1'b1;
              entry_d = '{last: 1'b0, data: hold_q};
            end
            hold_d     = shreg_d;
            hold_vld_d = 1'b1;
            bit_cnt_d  = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BC_W'(1);
          end
        end
        if (frameo_n) begin
          // Residual bits or an empty packet are flagged and discarded.
          if ((bit_cnt_d != '0) || !hold_vld_d) set_part = 1'b1;
          bit_cnt_d = '0;
          state_d   = hold_vld_d ? FLUSH : IDLE;
        end
      end
      default: begin
        if (state_q == FLUSH) begin
          push_d     = 1'b1;
          entry_d    = '{last: 1'b1, data: hold_q};
          hold_vld_d = 1'b0;
          pkt_cnt_d  = pkt_cnt_q + CNT_W'(1);
        end
        // FLUSH also serves as IDLE so a new frame may start immediately.
        if (!frameo_n) begin
          state_d = RECV;
          if (!valido_n) begin
            shreg_d[0] = dout;
            bit_cnt_d  = BC_W'(1);
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase

    err_part_d = set_part ? 1'b1 : (clr_err ? 1'b0 : err_part_q);
    err_ovf_d  = w_drop   ? 1'b1 : (clr_err ? 1'b0 : err_ovf_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      push_q     <= 1'b0;
      entry_q    <= '0;
      pkt_cnt_q  <= '0;
      err_part_q <= 1'b0;
      err_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      push_q     <= push_d;
      entry_q    <= entry_d;
      pkt_cnt_q  <= pkt_cnt_d;
      err_part_q <= err_part_d;
      err_ovf_q  <= err_ovf_d;
    end
  end

  // Pushes are staged one cycle, so a byte lands in the FIFO two edges after its last bit.
  assign w_pop  = !fifo_empty && m_ready;
  assign w_drop = push_q && fifo_full && !w_pop;

  router_rx_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push_q),
    .pop_i   (m_ready),
    .din_i   (entry_q),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head         = rx_entry_t'(fifo_dout);
  assign m_valid      = !fifo_empty;
  assign m_data       = head.data;
  assign m_last       = head.last;
  assign pkt_count    = pkt_cnt_q;
  assign err_partial  = err_part_q;
  assign err_overflow = err_ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_router_port_rx.sv
// tb_router_port_rx - directed scoreboard bench for router_port_rx (rev 1.0)
`default_nettype none

module tb_router_port_rx;

  localparam int FIFO_DEPTH = 16;
  localparam int CNT_W      = 16;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             dout = 1'b0;
  logic             frameo_n = 1'b1;
  logic             valido_n = 1'b1;
  logic             m_ready = 1'b0;
  logic             clr_err = 1'b0;
  logic [7:0]       m_data;
  logic             m_last;
  logic             m_valid;
  logic [CNT_W-1:0] pkt_count;
  logic             err_partial;
  logic             err_overflow;

  always #5 clk = ~clk;

  router_port_rx #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .dout         (dout),
    .frameo_n     (frameo_n),
    .valido_n     (valido_n),
    .m_data       (m_data),
    .m_last       (m_last),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .pkt_count    (pkt_count),
    .err_partial  (err_partial),
    .err_overflow (err_overflow),
    .clr_err      (clr_err)
  );

  logic [8:0] exp_q [$];
  logic [7:0] pk [$];
  logic [8:0] e_ent;
  int n_assert = 0;
  int n_fail   = 0;
  int n_xfer   = 0;
  int exp_pkts = 0;
  int x0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted head byte is compared against the oldest expectation.
  always @(negedge clk) begin
    if (reset_n && m_valid && m_ready) begin
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e_ent = exp_q.pop_front();
        check("xfer_data", 32'(m_data), 32'(e_ent[7:0]));
        check("xfer_last", 32'(m_last), 32'(e_ent[8]));
        n_xfer++;
      end
    end
  end

  task automatic expect_pkt();
    for (int j = 0; j < pk.size(); j++)
      exp_q.push_back({(j == pk.size() - 1), pk[j]});
    if (pk.size() > 0) exp_pkts++;
  endtask

  task automatic send_bits(input int nextra, input logic [7:0] extra,
                           input int bub_at, input int bub_len);
    int nb = pk.size() * 8;
    int nbits = nb + nextra;
    for (int i = 0; i < nbits; i++) begin
      if (i == bub_at) begin
        for (int k = 0; k < bub_len; k++) begin
          frameo_n = 1'b0; valido_n = 1'b1; dout = 1'b0;
          @(posedge clk); #1;
        end
      end
      frameo_n = (i == nbits - 1);
      valido_n = 1'b0;
      dout     = (i < nb) ? pk[i / 8][i % 8] : extra[i - nb];
      @(posedge clk); #1;
    end
    frameo_n = 1'b1; valido_n = 1'b1; dout = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int i = 0;
    while ((exp_q.size() != 0 || m_valid) && i < budget) begin
      @(posedge clk); #1;
      i++;
    end
    check("drain_in_budget", 32'(i < budget), 32'd1);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_m_data", 32'(m_data), 0);
    check("rst_m_last", 32'(m_last), 0);
    check("rst_pkt_count", 32'(pkt_count), 0);
    check("rst_err_partial", 32'(err_partial), 0);
    check("rst_err_overflow", 32'(err_overflow), 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // One-byte packet with latency check
    m_ready = 1'b1;
    pk.delete(); pk.push_back(8'hA5);
    expect_pkt();
    send_bits(0, 8'h00, -1, 0);
    check("lat_k_valid", 32'(m_valid), 0);
    @(posedge clk); #1;
    check("lat_k1_valid", 32'(m_valid), 0);
    @(posedge clk); #1;
    check("lat_k2_valid", 32'(m_valid), 1);
    check("lat_k2_data", 32'(m_data), 32'h0A5);
    check("lat_k2_last", 32'(m_last), 1);
    wait_drain(50);
    check("t1_pkt_count", 32'(pkt_count), 32'(exp_pkts));
    check("t1_err_partial", 32'(err_partial), 0);
    check("t1_err_overflow", 32'(err_overflow), 0);

    // Three bytes with a two-cycle bubble in byte 2
    pk.delete(); pk.push_back(8'h01); pk.push_back(8'h02); pk.push_back(8'h03);
    expect_pkt();
    x0 = n_xfer;
    send_bits(0, 8'h00, 11, 2);
    wait_drain(50);
    check("t2_xfers", 32'(n_xfer - x0), 3);
    check("t2_pkt_count", 32'(pkt_count), 32'(exp_pkts));
    check("t2_err_partial", 32'(err_partial), 0);

    // 12-bit packet: one full byte plus residual
    pk.delete(); pk.push_back(8'hFF);
    expect_pkt();
    send_bits(4, 8'h05, -1, 0);
    wait_drain(50);
    check("t3_err_partial", 32'(err_partial), 1);
    check("t3_pkt_count", 32'(pkt_count), 32'(exp_pkts));
    pulse_clr();
    check("t3_clr_partial", 32'(err_partial), 0);

    // Zero-byte packet
    frameo_n = 1'b0; valido_n = 1'b1;
    @(posedge clk); #1;
    frameo_n = 1'b1;
    @(posedge clk); #1;
    check("t3z_err_partial", 32'(err_partial), 1);
    repeat (3) begin @(posedge clk); #1; end
    check("t3z_no_output", 32'(m_valid), 0);
    check("t3z_pkt_count", 32'(pkt_count), 32'(exp_pkts));
    pulse_clr();
    check("t3z_clr_partial", 32'(err_partial), 0);

    // Overflow: 20 bytes into a 16-entry FIFO with sink stalled
    m_ready = 1'b0;
    pk.delete();
    for (int b = 0; b < 20; b++) pk.push_back(8'(b));
    for (int b = 0; b < FIFO_DEPTH; b++) exp_q.push_back({1'b0, 8'(b)});
    exp_pkts++;
    send_bits(0, 8'h00, -1, 0);
    repeat (4) begin @(posedge clk); #1; end
    check("t4_m_valid", 32'(m_valid), 1);
    check("t4_head_data", 32'(m_data), 32'h00);
    check("t4_head_last", 32'(m_last), 0);
    check("t4_err_overflow", 32'(err_overflow), 1);
    check("t4_pkt_count", 32'(pkt_count), 32'(exp_pkts));
    x0 = n_xfer;
    m_ready = 1'b1;
    wait_drain(100);
    repeat (3) begin @(posedge clk); #1; end
    check("t4_drained", 32'(n_xfer - x0), 16);
    check("t4_empty", 32'(m_valid), 0);

    // Asynchronous reset mid-packet
    for (int i = 0; i < 5; i++) begin
      frameo_n = 1'b0; valido_n = 1'b0; dout = i[0];
      @(posedge clk); #1;
    end
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_rst_m_valid", 32'(m_valid), 0);
    check("t5_rst_m_data", 32'(m_data), 0);
    check("t5_rst_pkt_count", 32'(pkt_count), 0);
    check("t5_rst_err_overflow", 32'(err_overflow), 0);
    check("t5_rst_err_partial", 32'(err_partial), 0);
    exp_pkts = 0;
    exp_q.delete();
    frameo_n = 1'b1; valido_n = 1'b1; dout = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    pk.delete(); pk.push_back(8'h3C);
    expect_pkt();
    x0 = n_xfer;
    send_bits(0, 8'h00, -1, 0);
    wait_drain(50);
    check("t5_xfers", 32'(n_xfer - x0), 1);
    check("t5_pkt_count", 32'(pkt_count), 32'(exp_pkts));

    // Back-to-back frames: second starts in the FLUSH cycle
    x0 = n_xfer;
    pk.delete(); pk.push_back(8'h11);
    expect_pkt();
    send_bits(0, 8'h00, -1, 0);
    pk.delete(); pk.push_back(8'h22);
    expect_pkt();
    send_bits(0, 8'h00, -1, 0);
    wait_drain(50);
    check("t6_xfers", 32'(n_xfer - x0), 2);
    check("t6_pkt_count", 32'(pkt_count), 32'(exp_pkts));
    check("t6_err_partial", 32'(err_partial), 0);
    check("t6_err_overflow", 32'(err_overflow), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
